// File: rtl/rect_draw_arbiter_pkg.sv
// Shared widths, screen geometry and FSM encoding for the rectangle draw arbiter.
package draw_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rect_draw_arbiter_if.sv
// Requester bundle plus the vga_adapter pixel-write port, shared by game side and arbiter.
interface rect_draw_if
  import draw_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*X_W-1:0]   rect_x;
  logic [N_REQ*Y_W-1:0]   rect_y;
  logic [N_REQ*X_W-1:0]   rect_w;
  logic [N_REQ*Y_W-1:0]   rect_h;
  logic [N_REQ*COL_W-1:0] rect_colour;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [X_W-1:0]         vga_x;
  logic [Y_W-1:0]         vga_y;
  logic [COL_W-1:0]       vga_colour;
  logic                   vga_plot;

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/rect_draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] j;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    j       = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = j;
      end
      j = (j == IDX_W'(N_REQ - 1)) ? '0 : j + IDX_W'(1);
    end
    win_oh = found ? (N_REQ'(1) << win_idx) : '0;
    any    = |req;
  end

endmodule

// File: rtl/rect_draw_arbiter.sv
// Round-robin shared rectangle filler feeding the vga_adapter pixel port, one pixel per clock.
// Define RECT_CLIP_EN to suppress vga_plot for pixels outside SCREEN_W x SCREEN_H.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches the winner's rectangle
// DRAW  | rastering row-major, one registered pixel per clock
// DONE  | one cycle: done pulse to winner, grant dropped, pointer advanced
module rect_draw_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic  CLOCK_50,
  input  logic  resetn,
  rect_draw_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [X_W-1:0]     x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [Y_W-1:0]     y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic [X_W-1:0]     vga_x_q, vga_x_d;
  logic [Y_W-1:0]     vga_y_q, vga_y_d;
  logic [COL_W-1:0]   vga_colour_q, vga_colour_d;
  logic               vga_plot_q, vga_plot_d;

  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic               on_screen;

  logic [X_W-1:0]     rx [N_REQ];
  logic [Y_W-1:0]     ry [N_REQ];
  logic [X_W-1:0]     rw [N_REQ];
  logic [Y_W-1:0]     rh [N_REQ];
  logic [COL_W-1:0]   rc [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign rx[g] = bus.rect_x[g*X_W +: X_W];
    assign ry[g] = bus.rect_y[g*Y_W +: Y_W];
    assign rw[g] = bus.rect_w[g*X_W +: X_W];
    assign rh[g] = bus.rect_h[g*Y_W +: Y_W];
    assign rc[g] = bus.rect_colour[g*COL_W +: COL_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any_req)
  );

`ifdef RECT_CLIP_EN
  // One extra bit so off-screen pixels are judged before the output wraps.
  logic [X_W:0] ux;
  logic [Y_W:0] uy;
  assign ux        = {1'b0, x0_q} + {1'b0, cx_q};
  assign uy        = {1'b0, y0_q} + {1'b0, cy_q};
  assign on_screen = (ux < (X_W+1)'(SCREEN_W)) && (uy < (Y_W+1)'(SCREEN_H));
`else
  assign on_screen = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    col_d        = col_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    grant_d      = grant_q;
    done_d       = '0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          x0_d    = rx[win_idx];
          y0_d    = ry[win_idx];
          w_d     = rw[win_idx];
          h_d     = rh[win_idx];
          col_d   = rc[win_idx];
          win_d   = win_idx;
          grant_d = win_oh;
          cx_d    = '0;
          cy_d    = '0;
          state_d = (rw[win_idx] == '0 || rh[win_idx] == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        vga_x_d      = x0_q + cx_q;
        vga_y_d      = y0_q + cy_q;
        vga_colour_d = col_q;
        vga_plot_d   = on_screen;
        if (cx_q == w_q - X_W'(1)) begin
          cx_d = '0;
          cy_d = cy_q + Y_W'(1);
          if (cy_q == h_q - Y_W'(1)) state_d = DONE;
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end
      DONE: begin
        done_d  = N_REQ'(1) << win_q;
        grant_d = '0;
        ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Directed bench for rect_draw_arbiter: raster order, round-robin, zero size, clip, reset, clear screen.
module tb_rect_draw_arbiter;
  import draw_pkg::*;

  logic clk;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  rect_draw_if #(.N_REQ(4)) bus ();

  rect_draw_arbiter #(.N_REQ(4)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int idx, input int x, input int y, input int w, input int h,
                          input int c);
    bus.rect_x[idx*X_W +: X_W]           = X_W'(x);
    bus.rect_y[idx*Y_W +: Y_W]           = Y_W'(y);
    bus.rect_w[idx*X_W +: X_W]           = X_W'(w);
    bus.rect_h[idx*Y_W +: Y_W]           = Y_W'(h);
    bus.rect_colour[idx*COL_W +: COL_W]  = COL_W'(c);
  endtask

  task automatic wait_done(input int budget, output int plots, output bit expired);
    plots   = 0;
    expired = 1'b1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (bus.done != '0) begin
        expired = 1'b0;
        break;
      end
      if (bus.vga_plot) plots++;
    end
  endtask

  int  plots, t, gcyc, wh_prev, wh, idx, bc, pc, lastx, lasty, lastc, px, py;
  bit  expired, clip_en, exp_plot;

  initial begin
`ifdef RECT_CLIP_EN
    clip_en = 1'b1;
`else
    clip_en = 1'b0;
`endif
    resetn          = 1'b0;
    bus.req         = '0;
    bus.rect_x      = '0;
    bus.rect_y      = '0;
    bus.rect_w      = '0;
    bus.rect_h      = '0;
    bus.rect_colour = '0;
    step(); step();
    resetn = 1'b1;
    step();

    // reset state
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_plot", 32'(bus.vga_plot), 0);
    chk("rst_x", 32'(bus.vga_x), 0);

    // 1: 2x2 fill at (10,20)
    set_rect(0, 10, 20, 2, 2, 7);
    bus.req = 4'b0001;
    step();
    chk("t1_grant", 32'(bus.grant), 1);
    chk("t1_plot0", 32'(bus.vga_plot), 0);
    chk("t1_busy", 32'(bus.busy), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_plot", 32'(bus.vga_plot), 1);
      chk("t1_x", 32'(bus.vga_x), 32'(10 + k % 2));
      chk("t1_y", 32'(bus.vga_y), 32'(20 + k / 2));
      chk("t1_col", 32'(bus.vga_colour), 7);
      chk("t1_grant_hold", 32'(bus.grant), 1);
    end
    step();
    chk("t1_done", 32'(bus.done), 1);
    chk("t1_plot_off", 32'(bus.vga_plot), 0);
    chk("t1_grant_off", 32'(bus.grant), 0);
    bus.req = '0;
    step();
    chk("t1_done_pulse", 32'(bus.done), 0);
    chk("t1_idle", 32'(bus.busy), 0);

    // 2: all requesters held from reset, sizes 1..4 x 1
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) set_rect(i, 20 + i, 30, i + 1, 1, i);
    bus.req = 4'b1111;
    step();
    resetn = 1'b1;
    wh_prev = 0;
    gcyc    = 0;
    for (int s = 0; s < 5; s++) begin
      idx = s % 4;
      wh  = idx + 1;
      t   = 0;
      while (bus.grant == '0 && t < 40) begin
        step();
        t++;
      end
      chk("t2_grant_wait", 32'(t < 40), 1);
      chk("t2_grant", 32'(bus.grant), 32'(1 << idx));
      if (s > 0) chk("t2_spacing", 32'(cyc - gcyc), 32'(wh_prev + 2));
      gcyc = cyc;
      if (s == 4) bus.req = '0;
      wait_done(40, plots, expired);
      chk("t2_done_wait", 32'(expired), 0);
      chk("t2_plots", 32'(plots), 32'(wh));
      chk("t2_done", 32'(bus.done), 32'(1 << idx));
      wh_prev = wh;
    end
    step();
    chk("t2_single_done", 32'(bus.done), 0);

    // 3: zero width
    set_rect(2, 5, 5, 0, 5, 3);
    bus.req = 4'b0100;
    step();
    chk("t3_grant", 32'(bus.grant), 4);
    chk("t3_plot_a", 32'(bus.vga_plot), 0);
    step();
    chk("t3_done", 32'(bus.done), 4);
    chk("t3_plot_b", 32'(bus.vga_plot), 0);
    bus.req = '0;
    step();

    // 4: 4x4 at (158,118) straddling the screen edge
    set_rect(3, 158, 118, 4, 4, 6);
    bus.req = 4'b1000;
    step();
    chk("t4_grant", 32'(bus.grant), 8);
    pc = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      px = 158 + k % 4;
      py = 118 + k / 4;
      exp_plot = clip_en ? (px < 160 && py < 120) : 1'b1;
      chk("t4_plot", 32'(bus.vga_plot), 32'(exp_plot));
      chk("t4_x", 32'(bus.vga_x), 32'(px));
      chk("t4_y", 32'(bus.vga_y), 32'(py));
      if (bus.vga_plot) pc++;
    end
    chk("t4_count", 32'(pc), clip_en ? 32'd4 : 32'd16);
    step();
    chk("t4_done", 32'(bus.done), 8);
    bus.req = '0;
    step();

    // 5: reset mid-draw, then pointer restarts at 0
    set_rect(1, 0, 10, 16, 2, 5);
    bus.req = 4'b0010;
    step();
    chk("t5_grant", 32'(bus.grant), 2);
    for (int k = 0; k < 5; k++) step();
    chk("t5_mid_plot", 32'(bus.vga_plot), 1);
    chk("t5_mid_x", 32'(bus.vga_x), 4);
    resetn = 1'b0;
    #1;
    chk("t5_rst_plot", 32'(bus.vga_plot), 0);
    chk("t5_rst_grant", 32'(bus.grant), 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    chk("t5_rst_x", 32'(bus.vga_x), 0);
    chk("t5_rst_col", 32'(bus.vga_colour), 0);
    set_rect(3, 50, 50, 1, 1, 2);
    bus.req = 4'b1010;
    step();
    chk("t5_no_done_rst", 32'(bus.done), 0);
    step();
    resetn = 1'b1;
    step();
    chk("t5_regrant", 32'(bus.grant), 2);
    chk("t5_no_done", 32'(bus.done), 0);
    wait_done(60, plots, expired);
    chk("t5_done_wait", 32'(expired), 0);
    chk("t5_plots", 32'(plots), 32);
    chk("t5_done", 32'(bus.done), 2);
    bus.req = '0;
    step();

    // 6: clear screen
    set_rect(0, 0, 0, 160, 120, 0);
    bus.req = 4'b0001;
    step();
    chk("t6_grant", 32'(bus.grant), 1);
    bc = 0; pc = 0; lastx = -1; lasty = -1; lastc = -1;
    while (bus.busy && bc < 20000) begin
      bc++;
      if (bus.vga_plot) begin
        pc++;
        lastx = int'(bus.vga_x);
        lasty = int'(bus.vga_y);
        lastc = int'(bus.vga_colour);
      end
      step();
    end
    chk("t6_busy_cycles", 32'(bc), 19201);
    chk("t6_plots", 32'(pc), 19200);
    chk("t6_last_x", 32'(lastx), 159);
    chk("t6_last_y", 32'(lasty), 119);
    chk("t6_last_col", 32'(lastc), 0);
    chk("t6_done", 32'(bus.done), 1);
    bus.req = '0;
    step();
    chk("t6_idle", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
